// File: rtl/psum_pkg.sv
// psum_pkg: shared widths, output queue depth and saturation bounds
// for the partial-sum accumulation buffer.
package psum_pkg;

  localparam int NUM_PE_D   = 4;
  localparam int IN_W_D     = 25;
  localparam int DATA_W_D   = 28;
  localparam int DEPTH_D    = 61;
  localparam int OUTQ_DEPTH = 4;

  function automatic logic signed [63:0] sat_max(
    input int w
  );
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(
    input int w
  );
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/psum_add_tree.sv
// psum_add_tree: registered signed sum of NUM_PE PE inputs plus a base.
// Ports: clk, rst_n, en (load), pe_data, base (old value), sum_q.
module psum_add_tree
  import psum_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_D,
  parameter int IN_W   = IN_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int SUM_W  = DATA_W_D + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_PE*IN_W-1:0]   pe_data,
  input  logic signed [DATA_W-1:0] base,
  output logic signed [SUM_W-1:0]  sum_q
);

  logic signed [SUM_W-1:0] acc;

  always_comb begin
    acc = SUM_W'(base);
    for (int i = 0; i < NUM_PE; i++) begin
      acc = acc
          + SUM_W'($signed(pe_data[i*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= acc;
    end
  end

endmodule

// File: rtl/psum_accum_buf.sv
// psum_accum_buf: multi-pass PE partial-sum accumulator with a DEPTH
// buffer, 2-stage add/clip pipe and a 4-entry valid/ready output queue.
// Ports: clk, rst_n, clear, in_valid/in_ready, in_first, in_last,
// pe_data, out_valid/out_ready/out_data, pass_done, sat_flag.
module psum_accum_buf
  import psum_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_D,
  parameter int IN_W   = IN_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int SAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [NUM_PE*IN_W-1:0] pe_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   pass_done,
  output logic                   sat_flag
);

  localparam int AW    = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + 4;
  localparam int PW    = $clog2(OUTQ_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic signed [63:0] SMAX =
    sat_max(DATA_W);
  localparam logic signed [63:0] SMIN =
    sat_min(DATA_W);
  localparam logic [AW-1:0] LAST_A =
    AW'(DEPTH - 1);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] q   [OUTQ_DEPTH];

  logic                     rdy_en;
  logic [AW-1:0]            addr;
  logic [AW-1:0]            s1_addr;
  logic [AW-1:0]            s2_addr;
  logic                     s1_v;
  logic                     s1_last;
  logic                     s2_v;
  logic                     s2_last;
  logic signed [SUM_W-1:0]  s1_sum;
  logic signed [DATA_W-1:0] s2_data;
  logic signed [DATA_W-1:0] old_val;
  logic signed [DATA_W-1:0] res;
  logic signed [63:0]       sum64;
  logic                     ovf;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            q_cnt;
  logic [CW:0]              pending;
  logic                     accept;
  logic                     enq;
  logic                     deq;

  // Credit covers queued results plus last beats still in the pipe,
  // so an accepted last beat always finds a free queue slot.
  assign pending = (CW+1)'(q_cnt)
                 + (CW+1)'(s1_v & s1_last)
                 + (CW+1)'(s2_v & s2_last);
  assign in_ready = rdy_en && !clear
                 && (pending < (CW+1)'(OUTQ_DEPTH));
  assign accept = in_valid && in_ready;
  assign old_val = in_first ? '0 : $signed(ram[addr]);

  assign enq = s2_v && s2_last && !clear;
  assign deq = out_valid && out_ready;
  assign out_valid = (q_cnt != '0);
  assign out_data = q[rd_ptr];

  psum_add_tree #(
    .NUM_PE (NUM_PE),
    .IN_W   (IN_W),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (accept),
    .pe_data (pe_data),
    .base    (old_val),
    .sum_q   (s1_sum)
  );

  always_comb begin
    sum64 = 64'(s1_sum);
    ovf = (sum64 > SMAX) || (sum64 < SMIN);
    res = s1_sum[DATA_W-1:0];
    if (SAT != 0 && sum64 > SMAX) begin
      res = SMAX[DATA_W-1:0];
    end else if (SAT != 0 && sum64 < SMIN) begin
      res = SMIN[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      addr      <= '0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_addr   <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_addr   <= '0;
      s2_data   <= '0;
      pass_done <= 1'b0;
      sat_flag  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      for (int i = 0; i < OUTQ_DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      if (clear) begin
        addr      <= '0;
        s1_v      <= 1'b0;
        s2_v      <= 1'b0;
        pass_done <= 1'b0;
        sat_flag  <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        q_cnt     <= '0;
      end else begin
        s1_v      <= accept;
        s1_last   <= in_last;
        s1_addr   <= addr;
        s2_v      <= s1_v;
        s2_last   <= s1_last;
        s2_addr   <= s1_addr;
        s2_data   <= res;
        pass_done <= accept && (addr == LAST_A);
        if (accept) begin
          addr <= (addr == LAST_A) ? '0
                                   : addr + 1'b1;
        end
        if (s1_v && ovf) begin
          sat_flag <= 1'b1;
        end
        if (enq) begin
          q[wr_ptr] <= s2_data;
          wr_ptr    <= wr_ptr + 1'b1;
        end
        if (deq) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        q_cnt <= q_cnt + CW'(enq) - CW'(deq);
      end
    end
  end

  // Buffer RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (s2_v && !s2_last && !clear) begin
      ram[s2_addr] <= s2_data;
    end
  end

endmodule

// File: tb/tb_psum_accum_buf.sv
// tb_psum_accum_buf: scoreboard bench for psum_accum_buf with a
// DEPTH=4 main instance and two 8-bit saturate/wrap instances.
module tb_psum_accum_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clear_m = 1'b0;
  logic        in_valid_m = 1'b0;
  logic        in_first_m = 1'b0;
  logic        in_last_m = 1'b0;
  logic        out_ready_m = 1'b1;
  logic [99:0] pe_m = '0;
  logic        in_ready_m;
  logic        out_valid_m;
  logic        pass_done_m;
  logic        sat_flag_m;
  logic [27:0] out_data_m;

  logic        clear_s = 1'b0;
  logic        in_valid_s = 1'b0;
  logic        in_first_s = 1'b0;
  logic        in_last_s = 1'b0;
  logic        out_ready_s = 1'b1;
  logic [31:0] pe_s = '0;
  logic        in_ready_a, in_ready_w;
  logic        out_valid_a, out_valid_w;
  logic        pass_done_a, pass_done_w;
  logic        sat_flag_a, sat_flag_w;
  logic [7:0]  out_data_a, out_data_w;

  int n_vec = 0;
  int n_err = 0;
  int pd_cnt = 0;
  int ov_cnt = 0;
  int n_acc = 0;
  logic bp_done = 1'b0;

  logic [27:0] exp_m[$];
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_w[$];
  logic [27:0] e_m;
  logic [7:0]  e_a, e_w;

  psum_accum_buf #(
    .NUM_PE(4), .IN_W(25), .DATA_W(28),
    .DEPTH(4), .SAT(1)
  ) dut_m (
    .clk(clk), .rst_n(rst_n), .clear(clear_m),
    .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_first(in_first_m), .in_last(in_last_m),
    .pe_data(pe_m), .out_valid(out_valid_m),
    .out_ready(out_ready_m), .out_data(out_data_m),
    .pass_done(pass_done_m), .sat_flag(sat_flag_m)
  );

  psum_accum_buf #(
    .NUM_PE(4), .IN_W(8), .DATA_W(8),
    .DEPTH(4), .SAT(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_s),
    .in_valid(in_valid_s), .in_ready(in_ready_a),
    .in_first(in_first_s), .in_last(in_last_s),
    .pe_data(pe_s), .out_valid(out_valid_a),
    .out_ready(out_ready_s), .out_data(out_data_a),
    .pass_done(pass_done_a), .sat_flag(sat_flag_a)
  );

  psum_accum_buf #(
    .NUM_PE(4), .IN_W(8), .DATA_W(8),
    .DEPTH(4), .SAT(0)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .clear(clear_s),
    .in_valid(in_valid_s), .in_ready(in_ready_w),
    .in_first(in_first_s), .in_last(in_last_s),
    .pe_data(pe_s), .out_valid(out_valid_w),
    .out_ready(out_ready_s), .out_data(out_data_w),
    .pass_done(pass_done_w), .sat_flag(sat_flag_w)
  );

  task automatic chk(input string nm,
                     input longint got,
                     input longint want);
    n_vec = n_vec + 1;
    if (got != want) begin
      n_err = n_err + 1;
      $display("FAIL %s got %0d want %0d",
               nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (pass_done_m) pd_cnt = pd_cnt + 1;
    if (out_valid_m) ov_cnt = ov_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_m && out_ready_m) begin
      n_vec = n_vec + 1;
      if (exp_m.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL main_out unexpected got %0d",
                 $signed(out_data_m));
      end else begin
        e_m = exp_m.pop_front();
        if (out_data_m !== e_m) begin
          n_err = n_err + 1;
          $display("FAIL main_out got %0d want %0d",
                   $signed(out_data_m), $signed(e_m));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_s) begin
      n_vec = n_vec + 1;
      if (exp_a.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL sat_out unexpected got %0d",
                 $signed(out_data_a));
      end else begin
        e_a = exp_a.pop_front();
        if (out_data_a !== e_a) begin
          n_err = n_err + 1;
          $display("FAIL sat_out got %0d want %0d",
                   $signed(out_data_a), $signed(e_a));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_w && out_ready_s) begin
      n_vec = n_vec + 1;
      if (exp_w.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL wrap_out unexpected got %0d",
                 $signed(out_data_w));
      end else begin
        e_w = exp_w.pop_front();
        if (out_data_w !== e_w) begin
          n_err = n_err + 1;
          $display("FAIL wrap_out got %0d want %0d",
                   $signed(out_data_w), $signed(e_w));
        end
      end
    end
  end

  task automatic send_m(input logic f, input logic l,
                        input int a, input int b,
                        input int c, input int d);
    int g;
    logic acc;
    in_valid_m = 1'b1;
    in_first_m = f;
    in_last_m = l;
    pe_m = {25'(d), 25'(c), 25'(b), 25'(a)};
    g = 0;
    acc = 1'b0;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = in_ready_m;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid_m = 1'b0;
    if (acc) n_acc = n_acc + 1;
    else chk("send_m_timeout", 0, 1);
  endtask

  task automatic send_s(input logic f, input logic l,
                        input int v);
    int g;
    logic acc;
    in_valid_s = 1'b1;
    in_first_s = f;
    in_last_s = l;
    pe_s = {4{8'(v)}};
    g = 0;
    acc = 1'b0;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = in_ready_a && in_ready_w;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid_s = 1'b0;
    if (!acc) chk("send_s_timeout", 0, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_m.size() + exp_a.size()
            + exp_w.size()) != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left",
        exp_m.size() + exp_a.size() + exp_w.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int a0;
    int o0;
    int pd0;
    int g;

    #3;
    chk("rst_in_ready", in_ready_m, 0);
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_out_data", out_data_m, 0);
    chk("rst_pass_done", pass_done_m, 0);
    chk("rst_sat_flag", sat_flag_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", in_ready_m, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", in_ready_m, 1);

    // Three passes of constant PE values.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (p == 2) exp_m.push_back(28'd24);
        send_m(p == 0, p == 2,
               p + 1, p + 1, p + 1, p + 1);
      end
    end
    drain();
    chk("pass_done_count", pd_cnt, 3);

    // Per-address values through first/mid/last.
    for (int i = 0; i < 4; i++)
      send_m(1, 0, 10 * (i + 1), 0, 0, 0);
    for (int i = 0; i < 4; i++)
      send_m(0, 0, -1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      exp_m.push_back(28'(10 * (i + 1) + 6));
      send_m(0, 1, 1, 2, 3, 4);
    end
    drain();

    // first+last bypass and latency.
    exp_m.push_back(28'd6);
    send_m(1, 1, -5, 3, 7, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid_m && lat < 20);
    chk("bypass_latency", lat, 3);
    drain();

    // Backpressure on the output queue.
    out_ready_m = 1'b0;
    a0 = n_acc;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          exp_m.push_back(28'(3 * k - 1));
          send_m(1, 1, k, 2 * k, 0, -1);
        end
        bp_done = 1'b1;
      end
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("bp_accepted", n_acc - a0, 4);
    chk("bp_in_ready", in_ready_m, 0);
    chk("bp_out_valid", out_valid_m, 1);
    chk("bp_head_data", out_data_m, 2);
    out_ready_m = 1'b1;
    g = 0;
    while (!bp_done && g < 100) begin
      @(posedge clk);
      g++;
    end
    chk("bp_done", bp_done, 1);
    drain();

    // Clear mid-pass.
    o0 = ov_cnt;
    send_m(1, 1, 1, 1, 1, 1);
    send_m(1, 1, 2, 2, 2, 2);
    clear_m = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", in_ready_m, 0);
    @(posedge clk);
    #1;
    clear_m = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("clear_no_out", ov_cnt - o0, 0);
    pd0 = pd_cnt;
    for (int v = 1; v <= 3; v++)
      send_m(1, 0, v, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_addr_pd3", pd_cnt - pd0, 0);
    send_m(1, 0, 4, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_addr_pd4", pd_cnt - pd0, 1);
    for (int v = 1; v <= 4; v++) begin
      exp_m.push_back(28'(10 + v));
      send_m(0, 1, 0, 0, 0, 10);
    end
    drain();

    // Saturate vs wrap at 8 bits.
    out_ready_s = 1'b0;
    exp_a.push_back(8'd127);
    exp_w.push_back(8'(-112));
    send_s(1, 1, 100);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_out_valid", out_valid_a, 1);
    chk("sat_flag_sat", sat_flag_a, 1);
    chk("sat_flag_wrap", sat_flag_w, 1);
    chk("main_no_sat", sat_flag_m, 0);
    out_ready_s = 1'b1;
    exp_a.push_back(8'h80);
    exp_w.push_back(8'd112);
    send_s(1, 1, -100);
    exp_a.push_back(8'd80);
    exp_w.push_back(8'd80);
    send_s(1, 1, 20);
    drain();

    // Reset while output pending.
    out_ready_s = 1'b0;
    send_s(1, 1, 5);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid_a", out_valid_a, 0);
    chk("arst_out_valid_w", out_valid_w, 0);
    chk("arst_sat_flag_a", sat_flag_a, 0);
    chk("arst_sat_flag_w", sat_flag_w, 0);
    chk("arst_out_data", out_data_a, 0);
    chk("arst_in_ready", in_ready_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_s = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accum_buf.md
PSUM_ACCUM_BUF -- requirements
Module: psum_accum_buf

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning number of PE partial-sum inputs (2..8).
REQ-002 SHALL have parameter IN_W, default 25, meaning signed width of each PE input.
REQ-003 SHALL have parameter DATA_W, default 28, meaning signed accumulator/buffer width (DATA_W >= IN_W).
REQ-004 SHALL have parameter DEPTH, default 61, meaning entries per pass (4..1024).
REQ-005 SHALL have parameter SAT, default 1, meaning 1 = saturate sums, 0 = wrap modulo 2^DATA_W.
REQ-006 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous flush of pointers, pipeline, output queue and sat_flag.
REQ-008 in_valid  input  1  beat valid; in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-009 in_first  input  1  beat belongs to first pass (old value treated as 0).
REQ-010 in_last  input  1  beat belongs to final pass (result goes to output, not written back).
REQ-011 pe_data  input  NUM_PE*IN_W  packed signed PE partial sums, PE0 in LSBs.
REQ-012 out_valid  output  1; out_ready  input  1; out_data  output  DATA_W  final sums, valid/ready handshake.
REQ-013 pass_done  output  1  one-cycle pulse when address DEPTH-1 is accepted.
REQ-014 sat_flag  output  1  sticky, set when any sum saturated (SAT=1) or overflowed (SAT=0).

Function
REQ-015 Address counter SHALL advance by one per accepted beat and wrap DEPTH-1 -> 0.
REQ-016 Accepted beat at cycle t SHALL read buffer[addr]; stage 1 (t+1) SHALL register sign-extended sum of all PE inputs plus old value (0 if in_first).
REQ-017 Stage 2 (t+2) SHALL register clipped/wrapped DATA_W result; non-last beats SHALL be written to buffer[addr] at end of t+2.
REQ-018 Last-pass beats SHALL enqueue into a 4-entry output queue at t+2; out_valid SHALL be asserted at t+3 when the queue was empty.
REQ-019 in_first && in_last SHALL output sum of PE inputs only, no buffer access.
REQ-020 in_ready SHALL be 0 when (queue occupancy + in-flight last beats) >= 4; otherwise 1; no beat SHALL ever be lost.
REQ-021 Saturation: results > 2^(DATA_W-1)-1 clip to max, < -2^(DATA_W-1) clip to min, sat_flag set same cycle as stage 2.
REQ-022 Out queue SHALL present data in acceptance order; simultaneous enqueue and dequeue SHALL keep occupancy constant.
REQ-023 in_first/in_last SHALL be sampled per beat; mixing modes within one pass is legal.
REQ-024 clear SHALL take priority over in_valid in the same cycle: beat not accepted, in_ready=0 during clear, counter=0, queue empty, in-flight writes discarded; buffer contents undefined afterwards.
REQ-025 No read-after-write hazard SHALL exist since DEPTH >= 4 exceeds pipeline depth 2.

Reset
REQ-026 rst_n low SHALL asynchronously set in_ready=0, out_valid=0, out_data=0, pass_done=0, sat_flag=0, address=0, pipeline valids=0, queue empty.
REQ-027 in_ready SHALL rise in the first clk edge after rst_n deasserts; buffer RAM not reset.
REQ-028 Reset mid-pass SHALL discard all in-flight data with no spurious out_valid.

Structure
REQ-029 Shared package psum_pkg SHALL hold default widths, OUTQ_DEPTH=4 and saturation min/max function.
REQ-030 One sub-module psum_add_tree (NUM_PE inputs, registered sum, sign extension) SHALL be instantiated; buffer is inferred RAM, no FIFO.

Verification
REQ-031 DEPTH=4, NUM_PE=4, pass1 in_first all PE=1, pass2 PE=2, pass3 in_last PE=3 -> out_data 4,12? no: 4+8+12=24 on all four beats, pass_done pulse each pass.
REQ-032 in_first&&in_last, PE={-5,3,7,1} -> out_data=6 at t+3.
REQ-033 DATA_W=IN_W=8, SAT=1, PE all 100 first+last -> out_data=127, sat_flag=1; SAT=0 -> out_data=-112, sat_flag=1.
REQ-034 Last pass with out_ready=0 for 10 cycles -> in_ready low after 4 beats, all beats later delivered in order.
REQ-035 clear asserted mid-pass after 2 beats -> no out_valid, next beat writes address 0.
REQ-036 rst_n pulsed while out_valid=1 -> out_valid=0 immediately, sat_flag=0.
